// File: rtl/bp_be_pkg.sv
// ---------------------------------------------------------------------------
// bp_be_pkg: scoreboard entry declaration and latency-width helper. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

`define BP_BE_SB_ENTRY_DECLARE(addr_w, lat_w) \
  typedef struct packed {                     \
    logic                v;                   \
    logic                w_v;                 \
    logic [(addr_w)-1:0] rd_addr;             \
    logic [(lat_w)-1:0]  cnt;                 \
  } bp_be_sb_entry_s;

`define BP_BE_SB_ENTRY_WIDTH(addr_w, lat_w) (2 + (addr_w) + (lat_w))

package bp_be_pkg;

  function automatic int bp_be_lat_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`endif

`default_nettype wire

// File: rtl/bp_be_scoreboard_hazard.sv
// ---------------------------------------------------------------------------
// bp_be_scoreboard_hazard: RAW hazard for one source against the youngest writer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bp_be_scoreboard_hazard
  import bp_be_pkg::*;
#(
  parameter int depth_p          = 4,
  parameter int reg_addr_width_p = 5,
  parameter int lat_width_p      = 2
) (
  input  logic [depth_p*`BP_BE_SB_ENTRY_WIDTH(reg_addr_width_p, lat_width_p)-1:0] entries,
  input  logic                        rs_r_v,
  input  logic [reg_addr_width_p-1:0] rs_addr,
  output logic                        hazard
);

  `BP_BE_SB_ENTRY_DECLARE(reg_addr_width_p, lat_width_p)

  bp_be_sb_entry_s [depth_p-1:0] ents;
  logic [depth_p-1:0]            match;
  logic [depth_p-1:0]            youngest;
  logic [lat_width_p-1:0]        cnt_sel;

  assign ents = entries;

  always_comb begin
    match = '0;
    for (int i = 0; i < depth_p; i++) begin
      match[i] = ents[i].v & ents[i].w_v & (ents[i].rd_addr == rs_addr);
    end
  end

  // Isolate the lowest set bit: stage 0 is the youngest writer.
  assign youngest = match & (~match + depth_p'(1));

  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < depth_p; i++) begin
      cnt_sel = cnt_sel | ({lat_width_p{youngest[i]}} & ents[i].cnt);
    end
  end

  assign hazard = rs_r_v & (rs_addr != '0) & (|match) & (cnt_sel != '0);

endmodule

`default_nettype wire

// File: rtl/bp_be_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// bp_be_issue_scoreboard: in-flight writer tracking, bypass valids, issue interlock. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bp_be_issue_scoreboard
  import bp_be_pkg::*;
#(
  parameter  int depth_p           = 4,
  parameter  int els_p             = 2,
  parameter  int reg_addr_width_p  = 5,
  localparam int lat_width_lp      = bp_be_lat_width(depth_p),
  localparam int inflight_width_lp = $clog2(depth_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                issue_v_i,
  input  logic [els_p-1:0]                    issue_rs_r_v_i,
  input  logic [els_p*reg_addr_width_p-1:0]   issue_rs_addr_i,
  input  logic                                issue_rd_w_v_i,
  input  logic [reg_addr_width_p-1:0]         issue_rd_addr_i,
  input  logic [lat_width_lp-1:0]             issue_lat_i,
  input  logic                                pipe_stall_i,
  input  logic                                flush_i,
  output logic                                issue_ready_o,
  output logic [depth_p-1:0]                  fwd_rd_v_o,
  output logic [depth_p*reg_addr_width_p-1:0] fwd_rd_addr_o,
  output logic [inflight_width_lp-1:0]        inflight_o
);

  `BP_BE_SB_ENTRY_DECLARE(reg_addr_width_p, lat_width_lp)

  bp_be_sb_entry_s [depth_p-1:0] stages;
  bp_be_sb_entry_s               new_entry;
  logic [els_p-1:0]              hazard;
  logic                          accept;
  logic                          lat_over;
  logic [lat_width_lp-1:0]       lat_sat;
  logic [inflight_width_lp-1:0]  inflight_cnt;

  for (genvar j = 0; j < els_p; j++) begin : g_src
    bp_be_scoreboard_hazard #(
      .depth_p          (depth_p),
      .reg_addr_width_p (reg_addr_width_p),
      .lat_width_p      (lat_width_lp)
    ) u_hazard (
      .entries (stages),
      .rs_r_v  (issue_rs_r_v_i[j]),
      .rs_addr (issue_rs_addr_i[j*reg_addr_width_p +: reg_addr_width_p]),
      .hazard  (hazard[j])
    );
  end

  // Ready is forced low while reset is asserted.
  assign issue_ready_o = reset_n_i & ~pipe_stall_i & ~flush_i & ~(|hazard);
  assign accept        = issue_v_i & issue_ready_o;

  assign lat_over = int'(issue_lat_i) > (depth_p - 1);
  assign lat_sat  = lat_over ? lat_width_lp'(depth_p - 1) : issue_lat_i;

  always_comb begin
    new_entry         = '0;
    new_entry.v       = accept;
    new_entry.w_v     = accept & issue_rd_w_v_i & (issue_rd_addr_i != '0);
    new_entry.rd_addr = accept ? issue_rd_addr_i : '0;
    new_entry.cnt     = accept ? lat_sat : '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stages <= '0;
    end else if (flush_i) begin
      stages <= '0;
    end else if (!pipe_stall_i) begin
      stages[0] <= new_entry;
      for (int i = 1; i < depth_p; i++) begin
        stages[i] <= stages[i-1];
        if (stages[i-1].cnt != '0) begin
          stages[i].cnt <= stages[i-1].cnt - lat_width_lp'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && accept) begin
      assert (!lat_over)
        else $warning("bp_be_issue_scoreboard: issue_lat_i=%0d above depth_p-1, saturated", issue_lat_i);
    end
  end

  for (genvar i = 0; i < depth_p; i++) begin : g_fwd
    assign fwd_rd_v_o[i] = stages[i].v & stages[i].w_v & (stages[i].cnt == '0);
    assign fwd_rd_addr_o[i*reg_addr_width_p +: reg_addr_width_p] = stages[i].rd_addr;
  end

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < depth_p; i++) begin
      inflight_cnt = inflight_cnt + inflight_width_lp'(stages[i].v);
    end
  end

  assign inflight_o = inflight_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bp_be_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_bp_be_issue_scoreboard: directed self-checking bench for the issue scoreboard. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bp_be_issue_scoreboard;

  logic        clk;
  logic        reset_n;
  logic        issue_v;
  logic [1:0]  rs_r_v;
  logic [9:0]  rs_addr;
  logic        rd_w_v;
  logic [4:0]  rd_addr;
  logic [1:0]  lat;
  logic        stall;
  logic        flush;
  logic        ready;
  logic [3:0]  fwd_v;
  logic [19:0] fwd_addr;
  logic [2:0]  inflight;

  // second instance with depth 3 for latency saturation
  logic        b_issue_v;
  logic [1:0]  b_rs_r_v;
  logic [9:0]  b_rs_addr;
  logic        b_rd_w_v;
  logic [4:0]  b_rd_addr;
  logic [1:0]  b_lat;
  logic        b_ready;
  logic [2:0]  b_fwd_v;
  logic [14:0] b_fwd_addr;
  logic [1:0]  b_inflight;

  int n_cmp = 0;
  int n_bad = 0;

  bp_be_issue_scoreboard #(.depth_p(4), .els_p(2), .reg_addr_width_p(5)) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .issue_v_i       (issue_v),
    .issue_rs_r_v_i  (rs_r_v),
    .issue_rs_addr_i (rs_addr),
    .issue_rd_w_v_i  (rd_w_v),
    .issue_rd_addr_i (rd_addr),
    .issue_lat_i     (lat),
    .pipe_stall_i    (stall),
    .flush_i         (flush),
    .issue_ready_o   (ready),
    .fwd_rd_v_o      (fwd_v),
    .fwd_rd_addr_o   (fwd_addr),
    .inflight_o      (inflight)
  );

  bp_be_issue_scoreboard #(.depth_p(3), .els_p(2), .reg_addr_width_p(5)) dut3 (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .issue_v_i       (b_issue_v),
    .issue_rs_r_v_i  (b_rs_r_v),
    .issue_rs_addr_i (b_rs_addr),
    .issue_rd_w_v_i  (b_rd_w_v),
    .issue_rd_addr_i (b_rd_addr),
    .issue_lat_i     (b_lat),
    .pipe_stall_i    (1'b0),
    .flush_i         (1'b0),
    .issue_ready_o   (b_ready),
    .fwd_rd_v_o      (b_fwd_v),
    .fwd_rd_addr_o   (b_fwd_addr),
    .inflight_o      (b_inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    issue_v = 0; rs_r_v = 0; rs_addr = 0; rd_w_v = 0; rd_addr = 0; lat = 0;
    stall = 0; flush = 0;
  endtask

  task automatic flush_pipe();
    @(negedge clk);
    idle();
    flush = 1;
    @(negedge clk);
    flush = 0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL init_ready got %b want 0", ready); end
    n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL init_inflight got %0d want 0", inflight); end
    @(negedge clk);
    reset_n = 1;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready got %b want 1", ready); end
    n_cmp++; if (fwd_v !== 4'b0) begin n_bad++; $display("FAIL rel_fwd_v got %b want 0000", fwd_v); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      issue_v = 1; rd_w_v = 1; rd_addr = 5'(k); lat = 2'd0;
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++; if (inflight !== 3'd3) begin n_bad++; $display("FAIL pre_rst_inflight got %0d want 3", inflight); end
    #2;
    reset_n = 0;
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", ready); end
    n_cmp++; if (fwd_v !== 4'b0) begin n_bad++; $display("FAIL rst_fwd_v got %b want 0000", fwd_v); end
    n_cmp++; if (fwd_addr !== 20'b0) begin n_bad++; $display("FAIL rst_fwd_addr got %h want 0", fwd_addr); end
    n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL rst_inflight got %0d want 0", inflight); end
    @(negedge clk);
    reset_n = 1;
    #1;
    n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL post_rst_inflight got %0d want 0", inflight); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready got %b want 1", ready); end
  endtask

  task automatic test_raw_latency();
    @(negedge clk);
    idle(); issue_v = 1; rd_w_v = 1; rd_addr = 5'd5; lat = 2'd2;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL raw_T_ready got %b want 1", ready); end
    @(negedge clk);
    idle(); issue_v = 1; rs_r_v = 2'b01; rs_addr = {5'd0, 5'd5};
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL raw_T1_ready got %b want 0", ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL raw_T2_ready got %b want 0", ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL raw_T3_ready got %b want 1", ready); end
    n_cmp++; if (fwd_v !== 4'b0100) begin n_bad++; $display("FAIL raw_T3_fwd_v got %b want 0100", fwd_v); end
    n_cmp++; if (fwd_addr[14:10] !== 5'd5) begin n_bad++; $display("FAIL raw_T3_addr2 got %0d want 5", fwd_addr[14:10]); end
  endtask

  task automatic test_youngest_wins();
    @(negedge clk);
    idle(); issue_v = 1; rd_w_v = 1; rd_addr = 5'd7; lat = 2'd3;
    @(negedge clk);
    idle(); issue_v = 1; rd_w_v = 1; rd_addr = 5'd7; lat = 2'd0;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL waw_issue_ready got %b want 1", ready); end
    @(negedge clk);
    idle(); issue_v = 1; rs_r_v = 2'b10; rs_addr = {5'd7, 5'd0};
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL young_ready got %b want 1", ready); end
    n_cmp++; if (fwd_v[1:0] !== 2'b01) begin n_bad++; $display("FAIL young_fwd_v got %b want 01", fwd_v[1:0]); end
    n_cmp++; if (fwd_addr[4:0] !== 5'd7) begin n_bad++; $display("FAIL young_addr0 got %0d want 7", fwd_addr[4:0]); end
    n_cmp++; if (fwd_addr[9:5] !== 5'd7) begin n_bad++; $display("FAIL young_addr1 got %0d want 7", fwd_addr[9:5]); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    idle(); issue_v = 1; rd_w_v = 1; rd_addr = 5'd3; lat = 2'd1;
    @(negedge clk);
    idle(); stall = 1; issue_v = 1; rs_r_v = 2'b01; rs_addr = {5'd0, 5'd3};
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d] got %b want 0", k, ready); end
      n_cmp++; if (fwd_addr[4:0] !== 5'd3 || fwd_v !== 4'b0) begin n_bad++; $display("FAIL stall_hold[%0d] got addr0=%0d fwd_v=%b want 3/0000", k, fwd_addr[4:0], fwd_v); end
      @(negedge clk);
    end
    stall = 0;
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL stall_drop_ready got %b want 0", ready); end
    n_cmp++; if (inflight !== 3'd1) begin n_bad++; $display("FAIL stall_drop_inflight got %0d want 1", inflight); end
    @(negedge clk);
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL stall_after_ready got %b want 1", ready); end
    n_cmp++; if (fwd_v !== 4'b0010) begin n_bad++; $display("FAIL stall_after_fwd_v got %b want 0010", fwd_v); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle(); issue_v = 1; rd_w_v = 1; rd_addr = 5'(10 + k); lat = 2'd3;
    end
    @(negedge clk);
    idle(); flush = 1; stall = 1; issue_v = 1; rd_w_v = 1; rd_addr = 5'd14;
    #1;
    n_cmp++; if (inflight !== 3'd4) begin n_bad++; $display("FAIL pre_flush_inflight got %0d want 4", inflight); end
    n_cmp++; if (fwd_v !== 4'b1000) begin n_bad++; $display("FAIL pre_flush_fwd_v got %b want 1000", fwd_v); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got %b want 0", ready); end
    @(negedge clk);
    idle();
    #1;
    n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL flush_inflight got %0d want 0", inflight); end
    n_cmp++; if (fwd_v !== 4'b0) begin n_bad++; $display("FAIL flush_fwd_v got %b want 0000", fwd_v); end
    @(negedge clk);
    #1;
    n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL flush_noaccept got %0d want 0", inflight); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    idle(); issue_v = 1; rd_w_v = 1; rd_addr = 5'd0; lat = 2'd3;
    @(negedge clk);
    idle(); issue_v = 1; rs_r_v = 2'b01; rs_addr = 10'd0;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready got %b want 1", ready); end
    n_cmp++; if (inflight !== 3'd1) begin n_bad++; $display("FAIL x0_inflight got %0d want 1", inflight); end
    @(negedge clk);
    idle();
    #1;
    n_cmp++; if (inflight !== 3'd2) begin n_bad++; $display("FAIL x0_accept_inflight got %0d want 2", inflight); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (fwd_v !== 4'b0) begin n_bad++; $display("FAIL x0_fwd_v[%0d] got %b want 0000", k, fwd_v); end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_lat_clamp();
    @(negedge clk);
    b_issue_v = 1; b_rd_w_v = 1; b_rd_addr = 5'd9; b_lat = 2'd3;
    @(negedge clk);
    b_rd_w_v = 0; b_rd_addr = 0; b_lat = 0; b_rs_r_v = 2'b01; b_rs_addr = {5'd0, 5'd9};
    #1;
    n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL clamp_T1_ready got %b want 0", b_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL clamp_T2_ready got %b want 0", b_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL clamp_T3_ready got %b want 1", b_ready); end
    n_cmp++; if (b_fwd_v !== 3'b100) begin n_bad++; $display("FAIL clamp_T3_fwd_v got %b want 100", b_fwd_v); end
    n_cmp++; if (b_fwd_addr[14:10] !== 5'd9) begin n_bad++; $display("FAIL clamp_T3_addr2 got %0d want 9", b_fwd_addr[14:10]); end
    @(negedge clk);
    b_issue_v = 0; b_rs_r_v = 0; b_rs_addr = 0;
  endtask

  initial begin
    reset_n = 0;
    idle();
    b_issue_v = 0; b_rs_r_v = 0; b_rs_addr = 0; b_rd_w_v = 0; b_rd_addr = 0; b_lat = 0;
    test_reset();
    flush_pipe();
    test_raw_latency();
    flush_pipe();
    test_youngest_wins();
    flush_pipe();
    test_stall();
    flush_pipe();
    test_flush();
    flush_pipe();
    test_x0();
    flush_pipe();
    test_lat_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
